axi_axil_rd_adapter: RTL and testbench
======================================

AXI_AXIL_RD_ADAPTER -- requirements
Module: axi_axil_rd_adapter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width on both ports.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 16, slave AXI4 read data width.
REQ-003 SHALL have parameter AXIL_DATA_WIDTH, default 32, master AXI-Lite read data width; legal only as AXI_DATA_WIDTH*2^k, k=0..3.
REQ-004 SHALL have parameter AXI_ID_WIDTH, default 8, AXI ID width.
REQ-005 SHALL have port clk, input, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have the slave AR channel, all inputs except arready: s_axi_arid [AXI_ID_WIDTH], s_axi_araddr [ADDR_WIDTH], s_axi_arlen [8], s_axi_arsize [3], s_axi_arburst [2], s_axi_arprot [3], s_axi_arvalid [1], s_axi_arready output [1].
REQ-008 SHALL have the slave R channel, all outputs except rready: s_axi_rid [AXI_ID_WIDTH], s_axi_rdata [AXI_DATA_WIDTH], s_axi_rresp [2], s_axi_rlast [1], s_axi_rvalid [1], s_axi_rready input [1].
REQ-009 SHALL have the master AR channel: m_axil_araddr output [ADDR_WIDTH], m_axil_arprot output [3], m_axil_arvalid output [1], m_axil_arready input [1].
REQ-010 SHALL have the master R channel: m_axil_rdata input [AXIL_DATA_WIDTH], m_axil_rresp input [2], m_axil_rvalid input [1], m_axil_rready output [1].

Function
REQ-011 SHALL use FSM states IDLE, ADDR, RESP, BEAT and ERR; one burst in flight at a time.
REQ-012 IDLE: s_axi_arready=1; on arvalid&arready, latch id, addr, len, size, burst and prot; clear the beat counter; go to ERR if the burst is illegal, else to ADDR.
REQ-013 Illegal burst: arburst=2'b11, or WRAP with arlen not in {1,3,7,15}.
REQ-014 A legal arsize larger than log2(AXI_DATA_WIDTH/8) SHALL be clamped to that maximum.
REQ-015 ADDR: m_axil_arvalid=1; m_axil_araddr = current address with the low log2(AXIL_DATA_WIDTH/8) bits cleared; m_axil_arprot = latched prot; on arready, go to RESP.
REQ-016 RESP: m_axil_rready=1; on rvalid, capture rdata and rresp into the word buffer; go to BEAT.
REQ-017 BEAT: s_axi_rvalid=1; s_axi_rdata = AXI_DATA_WIDTH lane of the buffer selected by address bits [log2(AXIL bytes)-1 : log2(AXI bytes)]; s_axi_rresp = buffered rresp; s_axi_rid = latched id; s_axi_rlast = (beat count == len).
REQ-018 On an R handshake with rlast set, the FSM SHALL return to IDLE.
REQ-019 Next-address rules, applied on each R handshake without rlast:
- INCR: address aligned down to size, plus 2^size.
- WRAP: same increment, wrapping within the (len+1)*2^size aligned boundary.
- FIXED: address unchanged.
REQ-020 After a non-last beat: if the burst is not FIXED and the next address falls in the same AXIL word, the FSM SHALL stay in BEAT, re-using the buffer with no new AXI-Lite read; otherwise it SHALL go to ADDR. FIXED always issues a new read.
REQ-021 ERR: s_axi_rvalid=1, s_axi_rdata=0, s_axi_rresp=2'b10 (SLVERR) for exactly len+1 beats, with rlast on the final beat; no m_axil_arvalid is issued; then return to IDLE.
REQ-022 All outputs SHALL be registered; m_axil_arvalid SHALL rise on the cycle after the AR acceptance.
REQ-023 Holding s_axi_rready low SHALL hold rvalid, rdata, rresp, rlast and rid stable.
REQ-024 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; there is no 4 KB boundary check.
REQ-025 Master handshakes SHALL respect valid-before-ready: m_axil_arvalid, once asserted, stays asserted with a stable address until arready.

Reset
REQ-026 rst_n low SHALL asynchronously force state IDLE and drive all outputs to 0, including s_axi_arready, s_axi_rvalid, m_axil_arvalid, m_axil_rready, addresses and data.
REQ-027 s_axi_arready SHALL assert on the first rising clk edge after rst_n is released.
REQ-028 Reset mid-burst SHALL abandon the burst with no further beats; the next AR after reset SHALL be processed normally.

Verification (AXI 16 / AXIL 32)
REQ-029 Single read: araddr 0x1002, len 0, size 1, INCR; AXIL returns 0xAABBCCDD, OKAY -> m_axil_araddr 0x1000; one beat with rdata 0xAABB, rlast 1, rid echoed.
REQ-030 INCR burst: araddr 0x2000, len 3, size 1 -> exactly two AXIL reads (0x2000, 0x2004) and four beats, low half then high half of each word.
REQ-031 WRAP burst: araddr 0x3006, len 3, size 1 -> beat addresses 0x3006, 0x3000, 0x3002, 0x3004; AXIL reads 0x3004, 0x3000, 0x3004.
REQ-032 FIXED burst: araddr 0x4000, len 2 -> three AXIL reads, all at 0x4000; AXIL rresp 2'b10 on the second read -> only beat 2 carries SLVERR.
REQ-033 Illegal burst: arburst 2'b11, len 1 -> two SLVERR beats with rdata 0 and zero m_axil_arvalid cycles; a WRAP with len 2 gives the same response for three beats.
REQ-034 Stress: random rready/arready/rvalid backpressure, then rst_n pulsed mid-burst -> outputs 0 immediately, arready back 1 cycle after release, next burst correct.

Source files
------------

// File: rtl/axi_axil_rd_adapter.sv
// axi_axil_rd_adapter
//   Converts AXI4 read bursts on a narrow slave port into single-word
//   AXI-Lite reads on a wider master port. One burst is handled at a time.
//   Each fetched AXI-Lite word is reused for every beat that falls inside it,
//   except for FIXED bursts, which fetch a new word for every beat.
//   Illegal bursts are answered locally with SLVERR beats and no master read.
//
// Ports
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   s_axi_ar*           : AXI4 read-address channel (slave side)
//   s_axi_r*            : AXI4 read-data channel (slave side)
//   m_axil_ar*          : AXI-Lite read-address channel (master side)
//   m_axil_r*           : AXI-Lite read-data channel (master side)
//   Every output is driven directly from a flop.
module axi_axil_rd_adapter #(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned AXI_DATA_WIDTH  = 16,
  parameter int unsigned AXIL_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH    = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // slave AR
  input  logic [AXI_ID_WIDTH-1:0]    s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]      s_axi_araddr,
  input  logic [7:0]                 s_axi_arlen,
  input  logic [2:0]                 s_axi_arsize,
  input  logic [1:0]                 s_axi_arburst,
  input  logic [2:0]                 s_axi_arprot,
  input  logic                       s_axi_arvalid,
  output logic                       s_axi_arready,
  // slave R
  output logic [AXI_ID_WIDTH-1:0]    s_axi_rid,
  output logic [AXI_DATA_WIDTH-1:0]  s_axi_rdata,
  output logic [1:0]                 s_axi_rresp,
  output logic                       s_axi_rlast,
  output logic                       s_axi_rvalid,
  input  logic                       s_axi_rready,
  // master AR
  output logic [ADDR_WIDTH-1:0]      m_axil_araddr,
  output logic [2:0]                 m_axil_arprot,
  output logic                       m_axil_arvalid,
  input  logic                       m_axil_arready,
  // master R
  input  logic [AXIL_DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]                 m_axil_rresp,
  input  logic                       m_axil_rvalid,
  output logic                       m_axil_rready
);

  localparam int unsigned AXI_LSB  = $clog2(AXI_DATA_WIDTH / 8);
  localparam int unsigned AXIL_LSB = $clog2(AXIL_DATA_WIDTH / 8);
  localparam int unsigned RATIO    = AXIL_DATA_WIDTH / AXI_DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] ONE       = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(RATIO - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ADDR_WIDTH'(AXIL_DATA_WIDTH / 8 - 1);
  localparam logic [2:0]            MAX_SIZE  = 3'(AXI_LSB);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, ADDR, RESP, BEAT, ERR} state_e;

  // burst context
  state_e                      state_q, state_d;
  logic [AXI_ID_WIDTH-1:0]     id_q, id_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic [7:0]                  len_q, len_d;
  logic [2:0]                  size_q, size_d;
  logic [1:0]                  burst_q, burst_d;
  logic [2:0]                  prot_q, prot_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic [AXIL_DATA_WIDTH-1:0]  wbuf_q, wbuf_d;
  logic [1:0]                  wresp_q, wresp_d;

  // registered outputs
  logic                        s_axi_arready_q, s_axi_arready_d;
  logic [AXI_ID_WIDTH-1:0]     s_axi_rid_q, s_axi_rid_d;
  logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata_q, s_axi_rdata_d;
  logic [1:0]                  s_axi_rresp_q, s_axi_rresp_d;
  logic                        s_axi_rlast_q, s_axi_rlast_d;
  logic                        s_axi_rvalid_q, s_axi_rvalid_d;
  logic [ADDR_WIDTH-1:0]       m_axil_araddr_q, m_axil_araddr_d;
  logic [2:0]                  m_axil_arprot_q, m_axil_arprot_d;
  logic                        m_axil_arvalid_q, m_axil_arvalid_d;
  logic                        m_axil_rready_q, m_axil_rready_d;

  logic [ADDR_WIDTH-1:0]       nxt_addr;
  logic                        wrap_len_ok;
  logic                        illegal;

  // Address of the beat following the current one.
  function automatic logic [ADDR_WIDTH-1:0] calc_next(
    input logic [ADDR_WIDTH-1:0] a,
    input logic [2:0]            sz,
    input logic [7:0]            len,
    input logic [1:0]            burst
  );
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] incr;
    logic [ADDR_WIDTH-1:0] wmask;
    step  = ONE << sz;
    incr  = (a & ~(step - ONE)) + step;
    // wrap window is (len+1) << size bytes, a power of two for legal WRAP lengths
    wmask = ((ADDR_WIDTH'(len) + ONE) << sz) - ONE;
    if (burst == BURST_FIXED)     calc_next = a;
    else if (burst == BURST_WRAP) calc_next = (a & ~wmask) | (incr & wmask);
    else                          calc_next = incr;
  endfunction

  // Narrow lane of the buffered word addressed by a.
  function automatic logic [AXI_DATA_WIDTH-1:0] lane_sel(
    input logic [AXIL_DATA_WIDTH-1:0] w,
    input logic [ADDR_WIDTH-1:0]      a
  );
    logic [ADDR_WIDTH-1:0] idx;
    idx = (a >> AXI_LSB) & LANE_MASK;
    lane_sel = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (idx == ADDR_WIDTH'(i)) lane_sel = w[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
    end
  endfunction

  always_comb begin
    wrap_len_ok = (s_axi_arlen == 8'd1) || (s_axi_arlen == 8'd3) ||
                  (s_axi_arlen == 8'd7) || (s_axi_arlen == 8'd15);
    illegal     = (s_axi_arburst == BURST_RSVD) ||
                  ((s_axi_arburst == BURST_WRAP) && !wrap_len_ok);
    nxt_addr    = calc_next(addr_q, size_q, len_q, burst_q);
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    prot_d  = prot_q;
    cnt_d   = cnt_q;
    wbuf_d  = wbuf_q;
    wresp_d = wresp_q;

    case (state_q)
      IDLE: begin
        if (s_axi_arvalid && s_axi_arready_q) begin
          id_d    = s_axi_arid;
          addr_d  = s_axi_araddr;
          len_d   = s_axi_arlen;
          size_d  = (s_axi_arsize > MAX_SIZE) ? MAX_SIZE : s_axi_arsize;
          burst_d = s_axi_arburst;
          prot_d  = s_axi_arprot;
          cnt_d   = '0;
          state_d = illegal ? ERR : ADDR;
        end
      end
      ADDR: begin
        if (m_axil_arvalid_q && m_axil_arready) state_d = RESP;
      end
      RESP: begin
        if (m_axil_rvalid && m_axil_rready_q) begin
          wbuf_d  = m_axil_rdata;
          wresp_d = m_axil_rresp;
          state_d = BEAT;
        end
      end
      BEAT: begin
        if (s_axi_rvalid_q && s_axi_rready) begin
          if (cnt_q == len_q) begin
            state_d = IDLE;
          end else begin
            cnt_d  = cnt_q + 8'd1;
            addr_d = nxt_addr;
            // next beat served from the buffer when it lies in the same word
            if ((burst_q != BURST_FIXED) &&
                ((nxt_addr >> AXIL_LSB) == (addr_q >> AXIL_LSB))) state_d = BEAT;
            else                                                 state_d = ADDR;
          end
        end
      end
      ERR: begin
        if (s_axi_rvalid_q && s_axi_rready) begin
          if (cnt_q == len_q) state_d = IDLE;
          else                cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered versions of what the next state presents.
    s_axi_arready_d  = (state_d == IDLE);
    m_axil_arvalid_d = (state_d == ADDR);
    m_axil_araddr_d  = addr_d & ~WORD_MASK;
    m_axil_arprot_d  = prot_d;
    m_axil_rready_d  = (state_d == RESP);
    s_axi_rvalid_d   = (state_d == BEAT) || (state_d == ERR);
    s_axi_rid_d      = id_d;
    s_axi_rdata_d    = (state_d == BEAT) ? lane_sel(wbuf_d, addr_d) : '0;
    s_axi_rresp_d    = (state_d == BEAT) ? wresp_d :
                       (state_d == ERR)  ? RESP_SLVERR : RESP_OKAY;
    s_axi_rlast_d    = s_axi_rvalid_d && (cnt_d == len_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      id_q             <= '0;
      addr_q           <= '0;
      len_q            <= '0;
      size_q           <= '0;
      burst_q          <= '0;
      prot_q           <= '0;
      cnt_q            <= '0;
      wbuf_q           <= '0;
      wresp_q          <= '0;
      s_axi_arready_q  <= 1'b0;
      s_axi_rid_q      <= '0;
      s_axi_rdata_q    <= '0;
      s_axi_rresp_q    <= '0;
      s_axi_rlast_q    <= 1'b0;
      s_axi_rvalid_q   <= 1'b0;
      m_axil_araddr_q  <= '0;
      m_axil_arprot_q  <= '0;
      m_axil_arvalid_q <= 1'b0;
      m_axil_rready_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      id_q             <= id_d;
      addr_q           <= addr_d;
      len_q            <= len_d;
      size_q           <= size_d;
      burst_q          <= burst_d;
      prot_q           <= prot_d;
      cnt_q            <= cnt_d;
      wbuf_q           <= wbuf_d;
      wresp_q          <= wresp_d;
      s_axi_arready_q  <= s_axi_arready_d;
      s_axi_rid_q      <= s_axi_rid_d;
      s_axi_rdata_q    <= s_axi_rdata_d;
      s_axi_rresp_q    <= s_axi_rresp_d;
      s_axi_rlast_q    <= s_axi_rlast_d;
      s_axi_rvalid_q   <= s_axi_rvalid_d;
      m_axil_araddr_q  <= m_axil_araddr_d;
      m_axil_arprot_q  <= m_axil_arprot_d;
      m_axil_arvalid_q <= m_axil_arvalid_d;
      m_axil_rready_q  <= m_axil_rready_d;
    end
  end

  assign s_axi_arready  = s_axi_arready_q;
  assign s_axi_rid      = s_axi_rid_q;
  assign s_axi_rdata    = s_axi_rdata_q;
  assign s_axi_rresp    = s_axi_rresp_q;
  assign s_axi_rlast    = s_axi_rlast_q;
  assign s_axi_rvalid   = s_axi_rvalid_q;
  assign m_axil_araddr  = m_axil_araddr_q;
  assign m_axil_arprot  = m_axil_arprot_q;
  assign m_axil_arvalid = m_axil_arvalid_q;
  assign m_axil_rready  = m_axil_rready_q;

endmodule

// File: tb/tb_axi_axil_rd_adapter.sv
// Scoreboard bench for axi_axil_rd_adapter (AXI 16-bit / AXI-Lite 32-bit).
module tb_axi_axil_rd_adapter;

  localparam int AW = 32;
  localparam int DW = 16;
  localparam int LW = 32;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] s_axi_arid;
  logic [AW-1:0] s_axi_araddr;
  logic [7:0]    s_axi_arlen;
  logic [2:0]    s_axi_arsize;
  logic [1:0]    s_axi_arburst;
  logic [2:0]    s_axi_arprot;
  logic          s_axi_arvalid;
  logic          s_axi_arready;
  logic [IW-1:0] s_axi_rid;
  logic [DW-1:0] s_axi_rdata;
  logic [1:0]    s_axi_rresp;
  logic          s_axi_rlast;
  logic          s_axi_rvalid;
  logic          s_axi_rready;
  logic [AW-1:0] m_axil_araddr;
  logic [2:0]    m_axil_arprot;
  logic          m_axil_arvalid;
  logic          m_axil_arready;
  logic [LW-1:0] m_axil_rdata;
  logic [1:0]    m_axil_rresp;
  logic          m_axil_rvalid;
  logic          m_axil_rready;

  always #5 clk = ~clk;

  axi_axil_rd_adapter #(
    .ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXIL_DATA_WIDTH(LW), .AXI_ID_WIDTH(IW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
  );

  typedef struct {
    logic [7:0]  id;
    logic [15:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  prot;
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_t;

  beat_t exp_beats[$];
  rd_t   exp_rds[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference address sequence, from the burst rules in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] a, input int burst,
                                             input int len, input int sz);
    longint unsigned step, al, total, base;
    step = longint'(1) << sz;
    al   = (longint'(a) / step) * step;
    if (burst == 0) return a;
    if (burst == 1) return 32'((al + step) % 64'h1_0000_0000);
    total = longint'(len + 1) * step;
    base  = (longint'(a) / total) * total;
    return 32'(base + ((al + step - base) % total));
  endfunction

  // err_read: -2 random responses, -1 all OKAY, n = SLVERR on the n-th read only
  task automatic push_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                            input int size, input int burst, input logic [2:0] prot,
                            input bit use_data, input logic [31:0] data, input int err_read);
    int          sz, nrd;
    logic [31:0] a, prev_word, wdata, sh;
    logic [1:0]  wresp;
    beat_t       b;
    rd_t         r;
    bit          bad;
    sz  = (size > 1) ? 1 : size;
    bad = (burst == 3) || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
    nrd = 0;
    a = addr; prev_word = '0; wdata = '0; wresp = '0;
    for (int i = 0; i <= len; i++) begin
      if (bad) begin
        b.id = id; b.data = '0; b.resp = 2'b10; b.last = (i == len);
        exp_beats.push_back(b);
        continue;
      end
      if (i > 0) a = model_next(a, burst, len, sz);
      if (i == 0 || burst == 0 || (a / 4) != prev_word) begin
        wdata = use_data ? data : $urandom;
        if (err_read == -2)
          wresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        else
          wresp = (nrd == err_read) ? 2'b10 : 2'b00;
        r.addr = (a / 4) * 4; r.prot = prot; r.data = wdata; r.resp = wresp;
        exp_rds.push_back(r);
        nrd++;
        prev_word = a / 4;
      end
      sh = wdata >> (((a % 4) / 2) * 16);
      b.id = id; b.data = sh[15:0]; b.resp = wresp; b.last = (i == len);
      exp_beats.push_back(b);
    end
  endtask

  task automatic send_ar(input logic [7:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst, input logic [2:0] prot);
    bit ok;
    @(posedge clk); #1;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = 3'(size); s_axi_arburst = 2'(burst); s_axi_arprot = prot;
    s_axi_arvalid = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (s_axi_arready) begin ok = 1'b1; break; end
    end
    chk("ar_accept", 64'(ok), 64'(1));
    @(posedge clk); #1;
    s_axi_arvalid = 1'b0;
  endtask

  task automatic run_burst(input logic [7:0] id, input logic [31:0] addr, input int len,
                           input int size, input int burst, input logic [2:0] prot,
                           input bit use_data, input logic [31:0] data, input int err_read);
    bit ok;
    push_burst(id, addr, len, size, burst, prot, use_data, data, err_read);
    send_ar(id, addr, len, size, burst, prot);
    ok = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (exp_beats.size() == 0) begin ok = 1'b1; break; end
    end
    chk("beats_drained", 64'(ok), 64'(1));
    chk("axil_reads_all_issued", 64'(exp_rds.size()), 64'(0));
    exp_beats.delete();
    exp_rds.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_arready"}, 64'(s_axi_arready), 64'(0));
    chk({tag, "_rvalid"}, 64'(s_axi_rvalid), 64'(0));
    chk({tag, "_rdata"}, 64'(s_axi_rdata), 64'(0));
    chk({tag, "_rresp_rlast_rid"}, 64'({s_axi_rresp, s_axi_rlast, s_axi_rid}), 64'(0));
    chk({tag, "_m_arvalid"}, 64'(m_axil_arvalid), 64'(0));
    chk({tag, "_m_araddr"}, 64'({m_axil_araddr, m_axil_arprot}), 64'(0));
    chk({tag, "_m_rready"}, 64'(m_axil_rready), 64'(0));
  endtask

  // AXI-Lite slave: checks requests against the expected read list and
  // returns the pre-chosen data with random delays.
  initial begin : axil_slave
    bit          pend, r_done, ar_stall;
    int          dly;
    logic [31:0] pdata, stall_addr;
    logic [1:0]  presp;
    rd_t         r;
    pend = 0; ar_stall = 0; dly = 0; pdata = '0; presp = '0; stall_addr = '0;
    m_axil_arready = 1'b0; m_axil_rvalid = 1'b0; m_axil_rdata = '0; m_axil_rresp = '0;
    forever begin
      @(negedge clk);
      r_done = 0;
      if (!rst_n) begin
        pend = 0; ar_stall = 0;
      end else begin
        if (ar_stall)
          chk("m_ar_held", 64'({m_axil_arvalid, m_axil_araddr}), 64'({1'b1, stall_addr}));
        if (m_axil_arvalid)
          chk("m_arvalid_expected", 64'(exp_rds.size() > 0), 64'(1));
        if (m_axil_arvalid && m_axil_arready) begin
          if (exp_rds.size() > 0) begin
            r = exp_rds.pop_front();
            chk("m_araddr", 64'(m_axil_araddr), 64'(r.addr));
            chk("m_arprot", 64'(m_axil_arprot), 64'(r.prot));
            pdata = r.data; presp = r.resp;
          end else begin
            pdata = '0; presp = '0;
          end
          pend = 1; dly = $urandom_range(0, 3);
        end
        ar_stall   = m_axil_arvalid && !m_axil_arready;
        stall_addr = m_axil_araddr;
        if (m_axil_rvalid && m_axil_rready) r_done = 1;
      end
      @(posedge clk); #1;
      m_axil_arready = ($urandom_range(0, 2) != 0);
      if (!rst_n || (m_axil_rvalid && r_done)) begin
        m_axil_rvalid = 1'b0;
      end else if (!m_axil_rvalid && pend) begin
        if (dly == 0) begin
          m_axil_rvalid = 1'b1; m_axil_rdata = pdata; m_axil_rresp = presp; pend = 0;
        end else begin
          dly--;
        end
      end
      if (!m_axil_rvalid) begin
        m_axil_rdata = $urandom;
        m_axil_rresp = 2'($urandom_range(0, 3));
      end
    end
  end

  // R-channel monitor: pops the scoreboard on each beat handshake.
  initial begin : r_monitor
    bit          stall;
    logic [26:0] saved;
    beat_t       b;
    stall = 0; saved = '0;
    s_axi_rready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 0;
      end else begin
        if (stall)
          chk("r_held", 64'({s_axi_rvalid, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}),
              64'({1'b1, saved}));
        if (s_axi_rvalid && s_axi_rready) begin
          chk("r_beat_expected", 64'(exp_beats.size() > 0), 64'(1));
          if (exp_beats.size() > 0) begin
            b = exp_beats.pop_front();
            chk("r_beat{id,data,resp,last}",
                64'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}),
                64'({b.id, b.data, b.resp, b.last}));
          end
        end
        stall = s_axi_rvalid && !s_axi_rready;
        saved = {s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast};
      end
      @(posedge clk); #1;
      s_axi_rready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

  initial begin : main
    int          r, len, burst, size;
    logic [31:0] addr;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
    s_axi_arburst = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;

    repeat (3) @(posedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("arready_before_first_edge", 64'(s_axi_arready), 64'(0));
    @(posedge clk); #1;
    chk("arready_after_release", 64'(s_axi_arready), 64'(1));

    // directed bursts
    run_burst(8'h5A, 32'h0000_1002, 0, 1, 1, 3'b010, 1, 32'hAABB_CCDD, -1);
    run_burst(8'h11, 32'h0000_2000, 3, 1, 1, 3'b000, 0, '0, -1);
    run_burst(8'h22, 32'h0000_3006, 3, 1, 2, 3'b001, 0, '0, -1);
    run_burst(8'h33, 32'h0000_4000, 2, 1, 0, 3'b100, 0, '0, 1);
    run_burst(8'h44, 32'h0000_5000, 1, 1, 3, 3'b000, 0, '0, -1);
    run_burst(8'h45, 32'h0000_5000, 2, 1, 2, 3'b000, 0, '0, -1);
    run_burst(8'h46, 32'h0000_6001, 5, 3, 1, 3'b111, 0, '0, -1);
    run_burst(8'h47, 32'hFFFF_FFFC, 3, 1, 1, 3'b000, 0, '0, -1);
    run_burst(8'h48, 32'h0000_7003, 4, 0, 1, 3'b000, 0, '0, -1);

    // random bursts with random backpressure on every handshake
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      burst = (r < 4) ? 1 : (r < 7) ? 2 : (r < 9) ? 0 : 3;
      len = $urandom_range(0, 15);
      if (burst == 2 && $urandom_range(0, 4) != 0) len = (4 << $urandom_range(0, 2)) - 1;
      if (burst == 2 && len == 3 && $urandom_range(0, 3) == 0) len = 15;
      size = $urandom_range(0, 3);
      addr = $urandom;
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFE0 | 32'($urandom_range(0, 31));
      run_burst(8'($urandom), addr, len, size, burst, 3'($urandom), 0, '0, -2);
    end

    // reset in the middle of a long burst
    push_burst(8'h77, 32'h0000_8000, 15, 1, 1, 3'b000, 0, '0, -1);
    send_ar(8'h77, 32'h0000_8000, 15, 1, 1, 3'b000);
    repeat (12) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    exp_beats.delete();
    exp_rds.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("arready_before_edge_after_reset", 64'(s_axi_arready), 64'(0));
    @(posedge clk); #1;
    chk("arready_one_edge_after_reset", 64'(s_axi_arready), 64'(1));

    run_burst(8'h78, 32'h0000_9002, 3, 1, 1, 3'b011, 0, '0, -1);
    run_burst(8'h79, 32'h0000_A004, 7, 1, 2, 3'b000, 0, '0, -2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
